// File: rtl/maluch_pkg.sv
// maluch_pkg: shared types for the Maluch 16-bit execute core
package maluch_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS = 16;
  typedef enum logic [3:0] {OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ALU = 4'h2, OP_CMP = 4'h3, OP_LDW = 4'h8} opcode_e;
  typedef enum logic [3:0] {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_SHL, F_SHR} funct_e;
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] funct;
    logic imm_present;
    logic [3:0] dest;
    logic [3:0] src;
    logic [15:0] imm;
  } instr_t;
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } csr_t;
  function automatic instr_t decode(input logic [31:0] w);
    return '{opcode: w[31:28], funct: w[27:24], imm_present: w[23], dest: w[19:16], src: w[3:0], imm: w[15:0]};
  endfunction
endpackage

// File: rtl/maluch_alu.sv
// maluch_alu: combinational ALU producing a result and fresh {V,C,N,Z} flags
module maluch_alu
  import maluch_pkg::*;
(
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic [3:0]  funct,
  output logic [15:0] result,
  output csr_t        csr_out
);
  logic [16:0] sum, dif, shl, shr;
  logic c, v;
  always_comb begin
    sum = {1'b0, src1} + {1'b0, src2};
    dif = {1'b0, src1} - {1'b0, src2};
    // one spare bit on the outgoing side captures the last bit shifted out
    shl = {1'b0, src1} << src2[3:0];
    shr = {src1, 1'b0} >> src2[3:0];
    result = src2;
    c = 1'b0;
    v = 1'b0;
    case (funct)
      F_ADD: begin
        result = sum[15:0];
        c = sum[16];
        v = (src1[15] == src2[15]) && (sum[15] != src1[15]);
      end
      F_SUB: begin
        result = dif[15:0];
        c = ~dif[16];
        v = (src1[15] != src2[15]) && (dif[15] != src1[15]);
      end
      F_AND: result = src1 & src2;
      F_OR:  result = src1 | src2;
      F_XOR: result = src1 ^ src2;
      F_NOT: result = ~src2;
      F_SHL: begin
        result = shl[15:0];
        c = shl[16];
      end
      F_SHR: begin
        result = shr[16:1];
        c = shr[0];
      end
      default: ;
    endcase
    csr_out = '{v: v, c: c, n: result[15], z: result == 16'h0};
  end
endmodule

// File: rtl/maluch_core.sv
// maluch_core: single-issue execute stage with decode reg, 16x16 regfile, csr and write-back
module maluch_core
  import maluch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags
);
  instr_t d;
  csr_t csr, alu_csr;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] src1, src2, alu_res;
  logic is_mov, is_alu, is_cmp, is_ldw;
  logic unused_rsvd;
  assign unused_rsvd = ^instr_in[22:20];
  always_ff @(posedge clk)
    if (_reset) d <= '0;
    else d <= decode(instr_in);
  always_comb begin
    is_mov = d.opcode == OP_MOV;
    is_alu = d.opcode == OP_ALU;
    is_cmp = d.opcode == OP_CMP;
    is_ldw = d.opcode == OP_LDW;
    src1 = regs[d.dest];
    src2 = d.imm_present ? d.imm : regs[d.src];
    wb_en = is_mov || is_alu || is_ldw;
    wb_addr = d.dest;
    wb_data = is_mov ? src2 : is_alu ? alu_res : is_ldw ? load_data : '0;
    mem_addr = is_ldw ? src2 : '0;
  end
  maluch_alu u_alu (
    .src1(src1),
    .src2(src2),
    .funct(d.funct),
    .result(alu_res),
    .csr_out(alu_csr)
  );
  // the reset edge wins over the pending write, so a mid-stream reset discards decode
  always_ff @(posedge clk)
    if (_reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      csr <= '0;
    end else begin
      if (wb_en) regs[wb_addr] <= wb_data;
      if (is_alu || is_cmp) csr <= alu_csr;
    end
  assign flags = csr;
endmodule

// File: tb/tb_maluch_core.sv
// tb_maluch_core: random and directed stimulus checked against an arithmetic reference model
module tb_maluch_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr_in = '0;
  logic [15:0] load_data = '0;
  logic [15:0] mem_addr, wb_data;
  logic wb_en;
  logic [3:0] wb_addr, flags;
  int errors = 0, checks = 0;
  int m_regs [16];
  int m_flags = 0;
  logic [31:0] cur = '0;
  logic [15:0] cur_ld = '0;

  maluch_core dut (
    .clk(clk), ._reset(rst), .instr_in(instr_in), .load_data(load_data),
    .mem_addr(mem_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input int op, input int f, input int ip, input int d, input int v);
    return {op[3:0], f[3:0], ip[0], 3'b000, d[3:0], v[15:0]};
  endfunction

  // expected outputs of instruction i given the model's current registers
  function automatic void ev(input logic [31:0] i, input logic [15:0] ld, output int en, output int addr,
                             output int data, output int ma, output int upd, output int nf);
    int op, f, a, b, r, c, v, sa, sb, ss, n;
    logic [15:0] av;
    op = i[31:28];
    f = i[27:24];
    addr = i[19:16];
    a = m_regs[addr];
    av = a[15:0];
    b = i[23] ? int'(i[15:0]) : m_regs[i[3:0]];
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    n = b % 16;
    c = 0;
    v = 0;
    case (f)
      0: begin r = a + b; c = int'(r > 65535); ss = sa + sb; v = int'(ss > 32767 || ss < -32768); end
      1: begin r = a - b; c = int'(a >= b); ss = sa - sb; v = int'(ss > 32767 || ss < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - b;
      6: begin r = a << n; c = n == 0 ? 0 : int'(av[16-n]); end
      7: begin r = a >> n; c = n == 0 ? 0 : int'(av[n-1]); end
      default: r = b;
    endcase
    r = r & 32'hFFFF;
    en = int'(op == 1 || op == 2 || op == 8);
    upd = int'(op == 2 || op == 3);
    data = op == 1 ? b : op == 2 ? r : op == 8 ? int'(ld) : 0;
    ma = op == 8 ? b : 0;
    nf = upd != 0 ? (v << 3) | (c << 2) | ((r >> 15) << 1) | int'(r == 0) : m_flags;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (instr %h)", name, act, exp, cur);
    end
  endtask

  task automatic compare();
    int en, addr, data, ma, upd, nf;
    ev(cur, cur_ld, en, addr, data, ma, upd, nf);
    chk("wb_en", int'(wb_en), en);
    if (en != 0) chk("wb_addr", int'(wb_addr), addr);
    if (en != 0 || upd == 0) chk("wb_data", int'(wb_data), data);
    chk("mem_addr", int'(mem_addr), ma);
    chk("flags", int'(flags), m_flags);
  endtask

  // present instr for capture at the next edge; afterwards the outputs reflect it executing
  task automatic step(input logic r, input logic [31:0] instr, input logic [15:0] ld);
    int en, addr, data, ma, upd, nf;
    @(negedge clk);
    rst = r;
    instr_in = instr;
    if (r) begin
      foreach (m_regs[k]) m_regs[k] = 0;
      m_flags = 0;
      cur = '0;
    end else begin
      ev(cur, cur_ld, en, addr, data, ma, upd, nf);
      if (en != 0) m_regs[addr] = data;
      m_flags = nf;
      cur = instr;
    end
    @(posedge clk);
    #1 load_data = ld;
    cur_ld = ld;
    #1 compare();
  endtask

  initial begin
    logic [31:0] ins;
    int ops [6] = '{0, 1, 2, 3, 8, 5};
    int edges [6] = '{0, 1, 16'h7FFF, 16'h8000, 16'hFFFF, 15};
    foreach (m_regs[k]) m_regs[k] = 0;
    step(1, '0, '0);
    step(1, enc(1, 0, 1, 9, 16'h9999), '0);
    chk("reset_flags", int'(flags), 0);
    chk("reset_wb_en", int'(wb_en), 0);
    step(0, enc(1, 0, 1, 1, 16'h1234), '0);
    chk("mov_en", int'(wb_en), 1);
    chk("mov_addr", int'(wb_addr), 1);
    chk("mov_data", int'(wb_data), 16'h1234);
    step(0, 32'h1080_1234, '0);
    chk("mov_raw_addr", int'(wb_addr), 0);
    step(0, enc(1, 0, 0, 7, 1), '0);
    chk("r1_readback", int'(wb_data), 16'h1234);
    step(0, enc(1, 0, 1, 2, 16'hFFFF), '0);
    step(0, enc(2, 0, 1, 2, 1), '0);
    chk("add_wrap_data", int'(wb_data), 0);
    step(0, '0, '0);
    chk("add_wrap_flags", int'(flags), 4'b0101);
    step(0, enc(1, 0, 1, 3, 16'h7FFF), '0);
    step(0, enc(2, 0, 1, 3, 1), '0);
    chk("add_ovf_data", int'(wb_data), 16'h8000);
    step(0, '0, '0);
    chk("add_ovf_flags", int'(flags), 4'b1010);
    step(0, enc(1, 0, 1, 4, 5), '0);
    step(0, enc(3, 1, 1, 4, 5), '0);
    chk("cmp_no_wb", int'(wb_en), 0);
    step(0, '0, '0);
    chk("cmp_flags", int'(flags), 4'b0101);
    step(0, enc(1, 0, 0, 8, 4), '0);
    chk("r4_kept", int'(wb_data), 5);
    step(0, enc(8, 0, 1, 5, 16'h0040), 16'hBEEF);
    chk("ldw_addr", int'(mem_addr), 16'h0040);
    chk("ldw_data", int'(wb_data), 16'hBEEF);
    step(0, enc(1, 0, 0, 9, 5), '0);
    chk("r5_readback", int'(wb_data), 16'hBEEF);
    step(0, enc(1, 0, 1, 6, 3), '0);
    step(0, enc(2, 0, 0, 6, 6), '0);
    chk("add_reg_form", int'(wb_data), 6);
    step(0, enc(1, 0, 1, 10, 16'h55), '0);
    step(1, enc(1, 0, 1, 11, 16'h66), '0);
    chk("midreset_flags", int'(flags), 0);
    chk("midreset_nop", int'(wb_en), 0);
    step(0, enc(1, 0, 0, 12, 10), '0);
    chk("midreset_no_write", int'(wb_data), 0);
    step(0, enc(1, 0, 0, 13, 6), '0);
    chk("midreset_regs_clear", int'(wb_data), 0);
    for (int t = 0; t < 3000; t++) begin
      ins = $urandom;
      ins[31:28] = 4'(ops[$urandom_range(5)]);
      if (ins[31:28] == 4'h5) ins[31:28] = 4'($urandom);
      if ($urandom_range(3) == 0) ins[15:0] = 16'(edges[$urandom_range(5)]);
      step($urandom_range(99) == 0, ins, 16'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
